// File: rtl/rob_commit_pkg.sv
// Shared processor package for the reorder buffer.
// Holds the default ROB depth, the physical register ID width and the
// per-entry record used by rob_commit.
package rob_commit_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_PREG_W = 7;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [ROB_PREG_W-1:0] pd_new;
    logic [ROB_PREG_W-1:0] pd_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit and mispredict flush.
// Ports:
//   i_clk, i_reset (async, active low)
//   dispatch : i_disp_valid/o_disp_ready, i_disp_has_dest, i_disp_pd_new, i_disp_pd_old,
//              o_disp_tag (tail index allocated on fire)
//   complete : i_cmpl_valid, i_cmpl_tag
//   free list: i_free_ready (not full), o_free_en/o_free_preg (old mapping released)
//   commit   : o_commit_valid, o_commit_tag
//   flush    : i_mispredict, i_mispredict_tag (entry kept as youngest)
//   status   : o_empty, o_count
// Entry storage uses rob_entry_t, so PREG_W is expected to equal ROB_PREG_W.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = ROB_PREG_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_disp_valid,
  output logic                     o_disp_ready,
  input  logic                     i_disp_has_dest,
  input  logic [PREG_W-1:0]        i_disp_pd_new,
  input  logic [PREG_W-1:0]        i_disp_pd_old,
  output logic [$clog2(DEPTH)-1:0] o_disp_tag,
  input  logic                     i_cmpl_valid,
  input  logic [$clog2(DEPTH)-1:0] i_cmpl_tag,
  input  logic                     i_free_ready,
  output logic                     o_free_en,
  output logic [PREG_W-1:0]        o_free_preg,
  output logic                     o_commit_valid,
  output logic [$clog2(DEPTH)-1:0] o_commit_tag,
  input  logic                     i_mispredict,
  input  logic [$clog2(DEPTH)-1:0] i_mispredict_tag,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]   r_head, r_tail;
  logic [IDX_W:0]   w_head_d, w_tail_d, w_count;
  logic [IDX_W-1:0] w_head_idx, w_tail_idx, w_flush_off;
  logic             w_disp_fire, w_commit;
  rob_entry_t       w_head_e;
  rob_entry_t       r_rob   [DEPTH];
  rob_entry_t       w_rob_d [DEPTH];

  assign w_head_idx  = r_head[IDX_W-1:0];
  assign w_tail_idx  = r_tail[IDX_W-1:0];
  assign w_count     = r_tail - r_head;
  assign w_head_e    = r_rob[w_head_idx];
  // Age of the branch entry relative to head; anything older-offset than this survives.
  assign w_flush_off = i_mispredict_tag - w_head_idx;

  assign o_disp_ready = (w_count != (IDX_W+1)'(DEPTH)) && !i_mispredict;
  assign w_disp_fire  = i_disp_valid && o_disp_ready;
  assign w_commit     = w_head_e.valid && w_head_e.done && (!w_head_e.has_dest || i_free_ready);

  assign o_disp_tag     = w_tail_idx;
  assign o_commit_valid = w_commit;
  assign o_commit_tag   = w_head_idx;
  assign o_free_en      = w_commit && w_head_e.has_dest;
  assign o_free_preg    = o_free_en ? PREG_W'(w_head_e.pd_old) : '0;
  assign o_empty        = (w_count == '0);
  assign o_count        = w_count;

  always_comb begin
    w_head_d = r_head + (IDX_W+1)'(w_commit);
    if (i_mispredict) begin
      w_tail_d = r_head + {1'b0, w_flush_off} + (IDX_W+1)'(1);
    end else begin
      w_tail_d = r_tail + (IDX_W+1)'(w_disp_fire);
    end

    for (int i = 0; i < DEPTH; i++) begin
      w_rob_d[i] = r_rob[i];
      // Flush has priority so a completion to a squashed tag is dropped.
      if (i_mispredict && ((IDX_W'(i) - w_head_idx) > w_flush_off)) begin
        w_rob_d[i] = '0;
      end else if (i_cmpl_valid && (i_cmpl_tag == IDX_W'(i)) && r_rob[i].valid) begin
        w_rob_d[i].done = 1'b1;
      end
      if (w_commit && (w_head_idx == IDX_W'(i))) begin
        w_rob_d[i] = '0;
      end
      if (w_disp_fire && (w_tail_idx == IDX_W'(i))) begin
        w_rob_d[i].valid    = 1'b1;
        w_rob_d[i].done     = 1'b0;
        w_rob_d[i].has_dest = i_disp_has_dest;
        w_rob_d[i].pd_new   = ROB_PREG_W'(i_disp_pd_new);
        w_rob_d[i].pd_old   = ROB_PREG_W'(i_disp_pd_old);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      r_head <= w_head_d;
      r_tail <= w_tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= w_rob_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 7;
  localparam int IW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              disp_valid, disp_ready, disp_has_dest;
  logic [PREG_W-1:0] disp_pd_new, disp_pd_old;
  logic [IW-1:0]     disp_tag;
  logic              cmpl_valid;
  logic [IW-1:0]     cmpl_tag;
  logic              free_ready, free_en;
  logic [PREG_W-1:0] free_preg;
  logic              commit_valid;
  logic [IW-1:0]     commit_tag;
  logic              mispredict;
  logic [IW-1:0]     mispredict_tag;
  logic              empty;
  logic [IW:0]       count;

  rob_commit #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_disp_valid     (disp_valid),
    .o_disp_ready     (disp_ready),
    .i_disp_has_dest  (disp_has_dest),
    .i_disp_pd_new    (disp_pd_new),
    .i_disp_pd_old    (disp_pd_old),
    .o_disp_tag       (disp_tag),
    .i_cmpl_valid     (cmpl_valid),
    .i_cmpl_tag       (cmpl_tag),
    .i_free_ready     (free_ready),
    .o_free_en        (free_en),
    .o_free_preg      (free_preg),
    .o_commit_valid   (commit_valid),
    .o_commit_tag     (commit_tag),
    .i_mispredict     (mispredict),
    .i_mispredict_tag (mispredict_tag),
    .o_empty          (empty),
    .o_count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0]     tag;
    logic              has_dest;
    logic [PREG_W-1:0] pd_old;
    logic              done;
  } sb_t;

  sb_t           sb_q[$];
  sb_t           sb_tmp;
  logic [IW-1:0] m_tail;
  logic          m_commit;
  int            m_pos;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: in-order model of live entries, updated at each negedge
  // from the inputs that will take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      m_tail = '0;
    end else begin
      check("count", 32'(count), 32'(sb_q.size()));
      check("empty", 32'(empty), 32'(sb_q.size() == 0));
      check("disp_ready", 32'(disp_ready), 32'((sb_q.size() != DEPTH) && !mispredict));
      m_commit = (sb_q.size() > 0) && sb_q[0].done && (!sb_q[0].has_dest || free_ready);
      check("commit_valid", 32'(commit_valid), 32'(m_commit));
      if (!free_en) check("free_preg_idle", 32'(free_preg), 32'(0));
      if (m_commit && commit_valid) begin
        check("commit_tag", 32'(commit_tag), 32'(sb_q[0].tag));
        check("free_en", 32'(free_en), 32'(sb_q[0].has_dest));
        check("free_preg", 32'(free_preg), sb_q[0].has_dest ? 32'(sb_q[0].pd_old) : 32'(0));
      end else begin
        check("free_en_idle", 32'(free_en), 32'(0));
      end
      if (mispredict) begin
        m_pos = -1;
        for (int i = 0; i < sb_q.size(); i++) if (sb_q[i].tag == mispredict_tag) m_pos = i;
        check("mp_tag_live", 32'(m_pos >= 0), 32'(1));
        if (m_pos >= 0) begin
          while (sb_q.size() > m_pos + 1) void'(sb_q.pop_back());
          m_tail = mispredict_tag + 4'd1;
        end
      end
      if (m_commit) void'(sb_q.pop_front());
      if (cmpl_valid) begin
        for (int i = 0; i < sb_q.size(); i++) begin
          if (sb_q[i].tag == cmpl_tag) begin
            sb_tmp = sb_q[i];
            sb_tmp.done = 1'b1;
            sb_q[i] = sb_tmp;
          end
        end
      end
      if (disp_valid && disp_ready) begin
        check("disp_tag", 32'(disp_tag), 32'(m_tail));
        sb_tmp.tag = m_tail;
        sb_tmp.has_dest = disp_has_dest;
        sb_tmp.pd_old = disp_pd_old;
        sb_tmp.done = 1'b0;
        sb_q.push_back(sb_tmp);
        m_tail = m_tail + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    disp_has_dest = 1'b0;
    disp_pd_new = '0;
    disp_pd_old = '0;
    cmpl_valid = 1'b0;
    cmpl_tag = '0;
    mispredict = 1'b0;
    mispredict_tag = '0;
    free_ready = 1'b1;
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_count"}, 32'(count), 32'(0));
    check({tag, "_empty"}, 32'(empty), 32'(1));
    check({tag, "_disp_ready"}, 32'(disp_ready), 32'(1));
    check({tag, "_free_en"}, 32'(free_en), 32'(0));
    check({tag, "_commit_valid"}, 32'(commit_valid), 32'(0));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    reset_outputs_check("rst");
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic dispatch(input int n, input logic has_dest, input int pd_base);
    for (int k = 0; k < n; k++) begin
      disp_valid = 1'b1;
      disp_has_dest = has_dest;
      disp_pd_old = PREG_W'(pd_base + k);
      disp_pd_new = PREG_W'(pd_base + k + 64);
      tick();
    end
    disp_valid = 1'b0;
  endtask

  task automatic complete(input int tag);
    cmpl_valid = 1'b1;
    cmpl_tag = IW'(tag);
    tick();
    cmpl_valid = 1'b0;
  endtask

  initial begin
    idle();
    #1 rst = 1'b0;
    #1 reset_outputs_check("init");
    tick();
    rst = 1'b1;

    // Three dest-carrying entries retire back to back.
    dispatch(3, 1'b1, 5);
    cmpl_valid = 1'b1; cmpl_tag = 4'd0; tick();
    cmpl_tag = 4'd1; #2;
    check("t1_preg0", 32'(free_preg), 32'(5));
    check("t1_cnt3", 32'(count), 32'(3));
    tick(); cmpl_tag = 4'd2; #2;
    check("t1_preg1", 32'(free_preg), 32'(6));
    tick(); cmpl_valid = 1'b0; #2;
    check("t1_preg2", 32'(free_preg), 32'(7));
    tick(); #2;
    check("t1_cnt0", 32'(count), 32'(0));

    // Full ROB, then simultaneous commit and wrapped dispatch.
    do_reset();
    dispatch(16, 1'b1, 0);
    #2;
    check("t2_full_ready", 32'(disp_ready), 32'(0));
    check("t2_full_cnt", 32'(count), 32'(16));
    cmpl_valid = 1'b1; cmpl_tag = 4'd0; tick();
    cmpl_tag = 4'd1; #2;
    check("t2_cnt16", 32'(count), 32'(16));
    check("t2_commit0", 32'(commit_valid), 32'(1));
    tick();
    cmpl_valid = 1'b0;
    disp_valid = 1'b1; disp_has_dest = 1'b0; disp_pd_old = 7'd99; #2;
    check("t2_wrap_tag", 32'(disp_tag), 32'(0));
    check("t2_both_commit", 32'(commit_valid), 32'(1));
    tick();
    disp_valid = 1'b0; #2;
    check("t2_cnt_kept", 32'(count), 32'(15));

    // Out-of-order completion, in-order retirement.
    do_reset();
    dispatch(3, 1'b0, 0);
    complete(2);
    complete(1);
    #2;
    check("t3_hold_a", 32'(commit_valid), 32'(0));
    tick(); #2;
    check("t3_hold_b", 32'(commit_valid), 32'(0));
    complete(0);
    #2;
    check("t3_tag0", 32'(commit_tag), 32'(0));
    tick(); #2;
    check("t3_tag1", 32'(commit_tag), 32'(1));
    tick(); #2;
    check("t3_tag2", 32'(commit_tag), 32'(2));
    tick(); #2;
    check("t3_empty", 32'(empty), 32'(1));

    // Free list full stalls a dest-carrying head.
    do_reset();
    dispatch(1, 1'b1, 9);
    free_ready = 1'b0;
    complete(0);
    for (int k = 0; k < 4; k++) begin
      #2;
      check("t4_stall_free_en", 32'(free_en), 32'(0));
      check("t4_stall_cnt", 32'(count), 32'(1));
      tick();
    end
    free_ready = 1'b1; #2;
    check("t4_release", 32'(free_preg), 32'(9));
    tick(); #2;
    check("t4_cnt0", 32'(count), 32'(0));

    // Mispredict on tag 2 flushes 3..5 without frees.
    do_reset();
    dispatch(6, 1'b1, 10);
    complete(3);
    complete(4);
    complete(5);
    mispredict = 1'b1; mispredict_tag = 4'd2;
    cmpl_valid = 1'b1; cmpl_tag = 4'd4; #2;
    check("t5_mp_block", 32'(disp_ready), 32'(0));
    tick();
    idle(); #2;
    check("t5_cnt3", 32'(count), 32'(3));
    disp_valid = 1'b1; disp_has_dest = 1'b1; disp_pd_old = 7'd30;
    #1;
    check("t5_next_tag", 32'(disp_tag), 32'(3));
    tick();
    disp_valid = 1'b0;
    complete(0);
    complete(1);
    complete(2);
    repeat (4) tick();
    #2;
    check("t5_left", 32'(count), 32'(1));
    complete(3);
    tick(); #2;
    check("t5_drained", 32'(empty), 32'(1));

    // Asynchronous reset mid-stream.
    do_reset();
    dispatch(8, 1'b1, 40);
    complete(0);
    complete(1);
    #1;
    check("t6_pre_free", 32'(free_en), 32'(1));
    rst = 1'b0;
    #1;
    reset_outputs_check("t6_async");
    tick();
    tick();
    rst = 1'b1;
    dispatch(1, 1'b0, 0);
    #2;
    check("t6_after_cnt", 32'(count), 32'(1));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
